ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single-port synchronous RAM (1-cycle read latency) between two requesters: the CPU (read/write) and the RAM readout/UART engine (read-only).
- Also sequences readout start. After the CPU raises its done level, the block waits a fixed delay, then issues a one-shot start pulse. This replaces the ad-hoc enable/address muxing and startup counter at top level.
- Sits between the CPU, the readout engine and the RAM instance.

Parameters:
AW, 6, RAM address width
DW, 16, RAM data width
MAX_CPU_STREAK, 4, consecutive CPU grants allowed while readout is waiting (min 1)
START_DELAY, 15, cycles from cpu_done rise to rd_start pulse (min 1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; valid with cpu_req
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_ack  out  1  one-cycle pulse: CPU request consumed
cpu_rdata  out  DW  CPU read data, valid when cpu_rvalid
cpu_rvalid  out  1  one-cycle pulse: CPU read data valid
rd_req  in  1  readout read request, held until rd_ack
rd_addr  in  AW  readout address
rd_ack  out  1  one-cycle pulse: readout request consumed
rd_rdata  out  DW  readout data, valid when rd_rvalid
rd_rvalid  out  1  one-cycle pulse: readout data valid
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_din  out  DW  RAM write data
ram_dout  in  DW  RAM read data
cpu_done  in  1  level from CPU: program finished, RAM ready for readout
rd_start  out  1  one-cycle pulse starting the readout engine

Behaviour:
- Clocking and reset:
  - All state changes on the rising edge of clk.
  - reset is synchronous, active-high, and has priority over everything else.
  - On reset: state=IDLE; streak=0; delay counter=0; started=0.
  - Also on reset, all outputs are 0: ram_en, ram_we, ram_addr, ram_din, acks, rvalids, rd_start.
  - Reset during ISSUE or DATA aborts the access. No ack or rvalid is emitted afterwards.
- Arbiter FSM (IDLE -> ISSUE -> DATA -> IDLE; one access per 3 cycles):
  - IDLE:
    - If no req, stay in IDLE with ram_en=0.
    - If req, choose a winner and register the RAM command (ram_en=1, ram_we, ram_addr, ram_din) plus the winner id. Go to ISSUE.
  - ISSUE:
    - The RAM command is driven for exactly this cycle.
    - The winner's ack=1 for this cycle.
    - At end of cycle: ram_en/ram_we return to 0; go to DATA.
  - DATA:
    - If the access was a read, the winner's rvalid=1 for this cycle, and its rdata = ram_dout.
    - Writes produce no rvalid.
    - Go to IDLE.
- Winner selection in IDLE:
  - Only cpu_req: CPU wins.
  - Only rd_req: readout wins.
  - Both, with streak < MAX_CPU_STREAK: CPU wins.
  - Both, with streak == MAX_CPU_STREAK: readout wins.
- Streak counter:
  - Increments on a CPU grant while rd_req=1, saturating at MAX_CPU_STREAK.
  - Clears on any readout grant.
  - Unchanged otherwise.
- Readout path:
  - Read-only: ram_we=0 and ram_din=0 whenever readout wins.
  - ram_addr and ram_din hold their last values while ram_en=0.
- Request and output timing:
  - Requests sampled in ISSUE or DATA are ignored. A requester must hold its req until it sees its ack.
  - A req still high in the IDLE after DATA is treated as a new request.
  - cpu_rdata and rd_rdata are driven from ram_dout. Their value is undefined outside the matching rvalid.
- Start sequencer:
  - started=0 and cpu_done=1: counter increments each cycle.
  - When the counter reaches START_DELAY, rd_start=1 for one cycle, started is set, and the counter stops.
  - If cpu_done drops before the pulse, the counter clears to 0.
  - After started is set, no further pulses occur until reset.
- Simultaneous events:
  - rd_start may pulse in any FSM state; it is independent of the arbiter.
  - Both reqs rising in the same cycle are resolved only by the selection rules above.

Test Plan:
- CPU write: cpu_req=1, cpu_we=1, addr=0x05, wdata=0xBEEF -> next cycle ram_en=1, ram_we=1, ram_addr=0x05, ram_din=0xBEEF, cpu_ack=1. No cpu_rvalid.
- CPU read: RAM[0x05]=0xBEEF, cpu_req=1, cpu_we=0, addr=0x05 -> cpu_ack in cycle N+1; cpu_rvalid=1 with cpu_rdata=0xBEEF in N+2. Back in IDLE at N+3.
- Fairness: cpu_req and rd_req held high continuously, MAX_CPU_STREAK=4 -> grant order CPU, CPU, CPU, CPU, RD, CPU, CPU, CPU, CPU, RD. One ack every 3 cycles.
- Readout alone: rd_req=1, rd_addr=0x3F -> rd_ack, then rd_rvalid with RAM[0x3F]; ram_we=0 throughout.
- Start sequencer: cpu_done rises at cycle 10, START_DELAY=15 -> single rd_start pulse at cycle 25. cpu_done kept high to cycle 100 -> no second pulse. cpu_done dropped at cycle 20 in a separate run -> no pulse.
- Reset mid-access: reset asserted during ISSUE of a CPU read -> next cycle all outputs 0, state IDLE. No cpu_rvalid follows. Streak reads 0 on the next contention.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Purpose: shares a 1-cycle-latency single-port RAM between the CPU (rd/wr) and the readout engine (rd only), and sequences readout start.
// Latency: ack one cycle after the request is taken in IDLE, read data the cycle after ack; one access per 3 cycles.
// Backpressure: requesters hold req until their ack; CPU may win at most MAX_CPU_STREAK times in a row while readout waits.
module ram_port_arbiter #(
    parameter int AW             = 6,
    parameter int DW             = 16,
    parameter int MAX_CPU_STREAK = 4,
    parameter int START_DELAY    = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic [DW-1:0] rd_rdata,
    output logic          rd_rvalid,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    input  logic          cpu_done,
    output logic          rd_start
);

    localparam int SW = $clog2(MAX_CPU_STREAK + 1);
    localparam int CW = $clog2(START_DELAY + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CPU_STREAK);
    localparam logic [CW-1:0] DELAY_MAX  = CW'(START_DELAY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          win_rd_q;   // 1 = current access belongs to the readout engine
    logic          acc_we_q;   // current access is a write (ram_we is gone by DATA)
    logic [SW-1:0] streak_q;
    logic [CW-1:0] cnt_q;
    logic          started_q;
    logic          any_req;
    logic          pick_rd;

    // Readout wins when alone, or when the CPU has used up its streak allowance.
    assign any_req = cpu_req | rd_req;
    assign pick_rd = rd_req & (~cpu_req | (streak_q == STREAK_MAX));

    // Next-state: a request in IDLE starts a fixed IDLE->ISSUE->DATA walk.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = DATA;
            DATA:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // RAM command register, winner bookkeeping and CPU streak counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            win_rd_q <= 1'b0;
            acc_we_q <= 1'b0;
            streak_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        ram_en   <= 1'b1;
                        win_rd_q <= pick_rd;
                        if (pick_rd) begin
                            ram_we   <= 1'b0;
                            ram_addr <= rd_addr;
                            ram_din  <= '0;
                            acc_we_q <= 1'b0;
                            streak_q <= '0;
                        end else begin
                            ram_we   <= cpu_we;
                            ram_addr <= cpu_addr;
                            ram_din  <= cpu_wdata;
                            acc_we_q <= cpu_we;
                            if (rd_req && (streak_q != STREAK_MAX))
                                streak_q <= streak_q + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // Command lives for exactly one cycle; address/data hold.
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Start sequencer: count cpu_done-high cycles, fire once, then stay quiet until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            started_q <= 1'b0;
        end else if (!started_q) begin
            if (cnt_q == DELAY_MAX)
                started_q <= 1'b1;
            else if (cpu_done)
                cnt_q <= cnt_q + 1'b1;
            else
                cnt_q <= '0;
        end
    end

    assign cpu_ack    = (state_q == ISSUE) & ~win_rd_q;
    assign rd_ack     = (state_q == ISSUE) &  win_rd_q;
    assign cpu_rvalid = (state_q == DATA)  & ~win_rd_q & ~acc_we_q;
    assign rd_rvalid  = (state_q == DATA)  &  win_rd_q & ~acc_we_q;
    assign cpu_rdata  = ram_dout;
    assign rd_rdata   = ram_dout;
    assign rd_start   = ~started_q & (cnt_q == DELAY_MAX);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Purpose: self-checking bench for ram_port_arbiter with a behavioural 1-cycle-latency RAM and a shadow-memory scoreboard.
// Latency: expects ack one cycle after request in IDLE, rvalid the cycle after ack, acks 3 cycles apart under contention.
// Backpressure: requests are held until ack is observed, then dropped in the same cycle.
module tb_ram_port_arbiter;

    localparam int AW   = 6;
    localparam int DW   = 16;
    localparam int MAXS = 4;
    localparam int SD   = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack, rd_rvalid;
    logic [DW-1:0] rd_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          cpu_done;
    logic          rd_start;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [DW-1:0] mem    [64];
    logic [DW-1:0] shadow [64];
    logic [DW-1:0] exp_q  [$];

    ram_port_arbiter #(.AW(AW), .DW(DW), .MAX_CPU_STREAK(MAXS), .START_DELAY(SD)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_rdata(rd_rdata), .rd_rvalid(rd_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .cpu_done(cpu_done), .rd_start(rd_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port synchronous RAM, one cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    task automatic test_reset();
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        rd_req = 1'b0; rd_addr = '0; cpu_done = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({ram_en, ram_we, ram_addr, ram_din, cpu_ack, cpu_rvalid, rd_ack, rd_rvalid, rd_start} !== 29'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {ram_en, ram_we, ram_addr, ram_din, cpu_ack, cpu_rvalid, rd_ack, rd_rvalid, rd_start});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One CPU access from IDLE: checks ack latency, RAM command, rvalid/rdata and return to IDLE.
    task automatic cpu_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data, input string tag);
        int lat;
        bit got;
        logic [DW-1:0] exp;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (cpu_ack) got = 1'b1;
        end
        cpu_req = 1'b0;
        vectors++;
        if (lat !== 1) begin
            miscompares++;
            $display("FAIL %s ack_latency: got %0d cycles, required 1", tag, lat);
        end
        if (got) begin
            if (we) shadow[addr] = data;
            else    exp_q.push_back(shadow[addr]);
            vectors++;
            if ({ram_en, ram_we, ram_addr, rd_ack} !== {1'b1, we, addr, 1'b0}) begin
                miscompares++;
                $display("FAIL %s issue_cmd: got en=%b we=%b addr=%h rd_ack=%b, required en=1 we=%b addr=%h rd_ack=0",
                         tag, ram_en, ram_we, ram_addr, rd_ack, we, addr);
            end
            if (we) begin
                vectors++;
                if (ram_din !== data) begin
                    miscompares++;
                    $display("FAIL %s issue_din: got %h, required %h", tag, ram_din, data);
                end
            end
            @(negedge clk);
            vectors++;
            if ({cpu_rvalid, rd_rvalid, ram_en, ram_we, cpu_ack} !== {~we, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL %s data_phase: got rvalid=%b rd_rvalid=%b en=%b we=%b ack=%b, required rvalid=%b others 0",
                         tag, cpu_rvalid, rd_rvalid, ram_en, ram_we, cpu_ack, ~we);
            end
            if (!we) begin
                exp = exp_q.pop_front();
                vectors++;
                if (cpu_rdata !== exp) begin
                    miscompares++;
                    $display("FAIL %s rdata: got %h, required %h", tag, cpu_rdata, exp);
                end
            end
            @(negedge clk);
            vectors++;
            if ({ram_en, cpu_ack, cpu_rvalid} !== 3'b000) begin
                miscompares++;
                $display("FAIL %s back_idle: got en/ack/rvalid=%b, required 000", tag, {ram_en, cpu_ack, cpu_rvalid});
            end
        end
    endtask

    task automatic test_cpu_write();
        cpu_access(1'b1, 6'h05, 16'hBEEF, "cpu_write_05");
        cpu_access(1'b1, 6'h3F, 16'h1234, "cpu_write_3f");
        cpu_access(1'b1, 6'h2A, 16'h0F0F, "cpu_write_2a");
    endtask

    task automatic test_cpu_read();
        cpu_access(1'b0, 6'h05, 16'h0000, "cpu_read_05");
        cpu_access(1'b0, 6'h2A, 16'hFFFF, "cpu_read_2a");
    endtask

    task automatic test_readout();
        int waited;
        bit got;
        logic [DW-1:0] exp;
        rd_req = 1'b1; rd_addr = 6'h3F;
        got = 1'b0;
        waited = 0;
        while (!got && waited < 10) begin
            @(negedge clk);
            waited++;
            vectors++;
            if (ram_we !== 1'b0) begin
                miscompares++;
                $display("FAIL readout_we: got %b, required 0", ram_we);
            end
            if (rd_ack) got = 1'b1;
        end
        rd_req = 1'b0;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL readout_ack: got no ack in %0d cycles, required ack", waited);
        end else begin
            exp_q.push_back(shadow[6'h3F]);
            vectors++;
            if ({ram_en, ram_addr, ram_din, cpu_ack} !== {1'b1, 6'h3F, 16'h0000, 1'b0}) begin
                miscompares++;
                $display("FAIL readout_cmd: got en=%b addr=%h din=%h cpu_ack=%b, required en=1 addr=3f din=0000 cpu_ack=0",
                         ram_en, ram_addr, ram_din, cpu_ack);
            end
            @(negedge clk);
            exp = exp_q.pop_front();
            vectors++;
            if ({rd_rvalid, cpu_rvalid, ram_we} !== 3'b100 || rd_rdata !== exp) begin
                miscompares++;
                $display("FAIL readout_data: got rvalid=%b cpu_rvalid=%b we=%b data=%h, required 1 0 0 data=%h",
                         rd_rvalid, cpu_rvalid, ram_we, rd_rdata, exp);
            end
            @(negedge clk);
        end
    endtask

    // Both requesters held high for n grants; grant k goes to readout when k mod (MAXS+1) == MAXS.
    task automatic test_contention(input int n, input string tag);
        int seen, last_cyc, waited;
        bit exp_rd;
        logic [DW-1:0] exp;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h05;
        rd_req  = 1'b1; rd_addr = 6'h3F;
        seen = 0; last_cyc = -1; waited = 0;
        while (seen < n && waited < 8) begin
            @(negedge clk);
            waited++;
            if (cpu_ack || rd_ack) begin
                exp_rd = ((seen % (MAXS + 1)) == MAXS);
                vectors++;
                if ({cpu_ack, rd_ack} !== {~exp_rd, exp_rd}) begin
                    miscompares++;
                    $display("FAIL %s grant_%0d: got cpu_ack=%b rd_ack=%b, required cpu_ack=%b rd_ack=%b",
                             tag, seen, cpu_ack, rd_ack, ~exp_rd, exp_rd);
                end
                if (last_cyc >= 0) begin
                    vectors++;
                    if ((cyc - last_cyc) != 3) begin
                        miscompares++;
                        $display("FAIL %s ack_spacing_%0d: got %0d cycles, required 3", tag, seen, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                exp_q.push_back(exp_rd ? shadow[6'h3F] : shadow[6'h05]);
                seen++;
                waited = 0;
                if (seen == n) begin
                    cpu_req = 1'b0;
                    rd_req  = 1'b0;
                end
                @(negedge clk);
                exp = exp_q.pop_front();
                vectors++;
                if ({cpu_rvalid, rd_rvalid} !== {~exp_rd, exp_rd} || (exp_rd ? rd_rdata : cpu_rdata) !== exp) begin
                    miscompares++;
                    $display("FAIL %s rvalid_%0d: got cpu_rv=%b rd_rv=%b data=%h, required cpu_rv=%b rd_rv=%b data=%h",
                             tag, seen - 1, cpu_rvalid, rd_rvalid, exp_rd ? rd_rdata : cpu_rdata, ~exp_rd, exp_rd, exp);
                end
            end
        end
        cpu_req = 1'b0;
        rd_req  = 1'b0;
        vectors++;
        if (seen != n) begin
            miscompares++;
            $display("FAIL %s grant_count: got %0d grants, required %0d", tag, seen, n);
        end
        @(negedge clk);
    endtask

    // Build a CPU streak of 3, reset during the ISSUE of the third read, then re-run contention.
    task automatic test_reset_mid_access();
        int acks, waited;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h05;
        rd_req  = 1'b1; rd_addr = 6'h3F;
        acks = 0; waited = 0;
        while (acks < 3 && waited < 20) begin
            @(negedge clk);
            waited++;
            if (cpu_ack) acks++;
        end
        vectors++;
        if (acks != 3) begin
            miscompares++;
            $display("FAIL mid_reset_setup: got %0d cpu acks, required 3", acks);
        end
        reset = 1'b1;
        cpu_req = 1'b0;
        rd_req  = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ram_en, ram_we, ram_addr, ram_din, cpu_ack, cpu_rvalid, rd_ack, rd_rvalid, rd_start} !== 29'd0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got %h, required 0",
                     {ram_en, ram_we, ram_addr, ram_din, cpu_ack, cpu_rvalid, rd_ack, rd_rvalid, rd_start});
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({cpu_rvalid, rd_rvalid, cpu_ack, rd_ack} !== 4'b0000) begin
                miscompares++;
                $display("FAIL mid_reset_quiet_%0d: got rv/ack=%b, required 0000", i, {cpu_rvalid, rd_rvalid, cpu_ack, rd_ack});
            end
        end
        test_contention(MAXS + 1, "post_reset_streak");
    endtask

    // Drive cpu_done per cycle from a window pattern and require exactly one pulse at pulse_cyc (-1 = none).
    task automatic run_start(input int last, input int on1, input int off1, input int on2, input int pulse_cyc, input string tag);
        reset = 1'b1;
        cpu_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i <= last; i++) begin
            vectors++;
            if (rd_start !== (i == pulse_cyc)) begin
                miscompares++;
                $display("FAIL %s cycle_%0d: got rd_start=%b, required %b", tag, i, rd_start, (i == pulse_cyc));
            end
            cpu_done = ((i >= on1) && (i < off1)) || ((on2 >= 0) && (i >= on2));
            @(negedge clk);
        end
        cpu_done = 1'b0;
    endtask

    task automatic test_start_seq();
        run_start(100, 10, 1000, -1, 10 + SD, "start_hold");
        run_start(35,  10, 20,   -1, -1,      "start_drop");
        run_start(70,  10, 20,   40, 40 + SD, "start_retry");
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_readout();
        test_contention(10, "fairness");
        test_reset_mid_access();
        test_start_seq();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
